// File: rtl/timer_pkg.sv
// Shared definitions for the timer register bank: address map, TCR write
// mask, reset value and the bus-side FSM state encoding.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  // TCR bits 6, 3 and 2 are reserved: never stored, always read back as 0
  localparam logic [7:0] TCR_WMASK   = 8'hB3;
  localparam logic [7:0] RESET_VALUE = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/timer_apb_slave.sv
// Bus responder for the timer: decodes TDR/TCR/TSR/TCNT, inserts programmable
// wait states, flags unmapped addresses with cpu_slverr and exports the
// control/reload values to the counter core.
module timer_apb_slave
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       cpu_clk,
  input  logic       cpu_reset_n,
  input  logic       cpu_sel,
  input  logic       cpu_enable,
  input  logic       cpu_write,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ready,
  output logic       cpu_slverr,
  output logic [7:0] cpu_rdata,
  output logic [7:0] tdr_out,
  output logic [7:0] tcr_out,
  input  logic       ovf_set,
  input  logic       udf_set,
  input  logic [7:0] cnt_in,
  output logic [1:0] tsr_out
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  state_t     state;
  logic [2:0] wait_cnt;
  logic [7:0] tdr;
  logic [7:0] tcr;
  logic [1:0] tsr;

  logic       access_ok;
  logic       commit;
  logic       mapped;
  logic [7:0] read_data;
  logic [1:0] w1c_mask;
  logic [1:0] tsr_next;

  // Transfer qualification, read mux and TSR next-state (set pulses win over W1C)
  always_comb begin
    access_ok = cpu_sel && cpu_enable;
    commit    = (state == ACCESS) && access_ok && (wait_cnt == 3'd0);
    mapped    = (cpu_address <= ADDR_TCNT);
    read_data = RESET_VALUE;
    case (cpu_address)
      ADDR_TDR:  read_data = tdr;
      ADDR_TCR:  read_data = tcr;
      ADDR_TSR:  read_data = {6'b0, tsr};
      ADDR_TCNT: read_data = cnt_in;
      default:   read_data = RESET_VALUE;
    endcase
    w1c_mask = 2'b00;
    if (commit && cpu_write && (cpu_address == ADDR_TSR)) begin
      w1c_mask = cpu_wdata[1:0];
    end
    tsr_next = (tsr & ~w1c_mask) | {udf_set, ovf_set};
  end

  // Bus FSM together with the register bank and the registered response
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      tdr        <= RESET_VALUE;
      tcr        <= RESET_VALUE;
      tsr        <= 2'b00;
      cpu_ready  <= 1'b0;
      cpu_slverr <= 1'b0;
      cpu_rdata  <= RESET_VALUE;
    end else begin
      tsr        <= tsr_next;
      cpu_ready  <= 1'b0;
      cpu_slverr <= 1'b0;
      cpu_rdata  <= RESET_VALUE;
      case (state)
        IDLE: begin
          if (cpu_sel && !cpu_enable) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          if (!cpu_sel) begin
            state <= IDLE;
          end else if (cpu_enable) begin
            state    <= ACCESS;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ACCESS: begin
          if (!access_ok) begin
            state <= IDLE;
          end else if (wait_cnt == 3'd0) begin
            cpu_ready  <= 1'b1;
            cpu_slverr <= !mapped;
            if (cpu_write) begin
              if (cpu_address == ADDR_TDR) begin
                tdr <= cpu_wdata;
              end else if (cpu_address == ADDR_TCR) begin
                tcr <= cpu_wdata & TCR_WMASK;
              end
            end else begin
              cpu_rdata <= read_data;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign tdr_out = tdr;
  assign tcr_out = tcr;
  assign tsr_out = tsr;

endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed bench for timer_apb_slave: two instances (WAIT_STATES 0 and 3)
// share one bus so every transfer exercises both latencies.
module tb_timer_apb_slave;

  logic       cpu_clk = 1'b0;
  logic       cpu_reset_n = 1'b0;
  logic       cpu_sel = 1'b0;
  logic       cpu_enable = 1'b0;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_address = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       ovf_set = 1'b0;
  logic       udf_set = 1'b0;
  logic [7:0] cnt_in = 8'h00;

  logic       ready0, err0, ready3, err3;
  logic [7:0] rdata0, tdr0, tcr0, rdata3, tdr3, tcr3;
  logic [1:0] tsr0, tsr3;

  int checks = 0;
  int failures = 0;

  int         lat0, lat3, n0;
  logic       got0, got3;
  logic [7:0] rd0, rd3;
  logic       e0, e3;

  timer_apb_slave #(.WAIT_STATES(0)) dut0 (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n), .cpu_sel(cpu_sel),
    .cpu_enable(cpu_enable), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_ready(ready0), .cpu_slverr(err0),
    .cpu_rdata(rdata0), .tdr_out(tdr0), .tcr_out(tcr0), .ovf_set(ovf_set),
    .udf_set(udf_set), .cnt_in(cnt_in), .tsr_out(tsr0)
  );

  timer_apb_slave #(.WAIT_STATES(3)) dut3 (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n), .cpu_sel(cpu_sel),
    .cpu_enable(cpu_enable), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_ready(ready3), .cpu_slverr(err3),
    .cpu_rdata(rdata3), .tdr_out(tdr3), .tcr_out(tcr3), .ovf_set(ovf_set),
    .udf_set(udf_set), .cnt_in(cnt_in), .tsr_out(tsr3)
  );

  always #5 cpu_clk = ~cpu_clk;

  // One full transfer; latencies counted in edges after the first edge that sees sel&enable
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    @(negedge cpu_clk);
    cpu_sel = 1'b1; cpu_enable = 1'b0; cpu_write = wr; cpu_address = addr; cpu_wdata = wd;
    @(negedge cpu_clk);
    cpu_enable = 1'b1;
    @(posedge cpu_clk);
    lat0 = 0; lat3 = 0; n0 = 0; got0 = 1'b0; got3 = 1'b0;
    rd0 = 8'hxx; rd3 = 8'hxx; e0 = 1'bx; e3 = 1'bx;
    for (int i = 1; i <= 20 && !got3; i++) begin
      @(posedge cpu_clk);
      #1;
      if (ready0) begin
        n0++;
        if (!got0) begin got0 = 1'b1; lat0 = i; rd0 = rdata0; e0 = err0; end
      end
      if (ready3) begin got3 = 1'b1; lat3 = i; rd3 = rdata3; e3 = err3; end
    end
    @(negedge cpu_clk);
    cpu_sel = 1'b0; cpu_enable = 1'b0;
    checks++;
    if (!got3) begin failures++; $display("[TB] FAIL xfer_timeout addr=%h got=no_ready exp=ready", addr); end
    checks++;
    if (n0 !== 1) begin failures++; $display("[TB] FAIL ws0_ready_pulses addr=%h got=%0d exp=1", addr, n0); end
    checks++;
    if (lat0 !== 1) begin failures++; $display("[TB] FAIL ws0_latency addr=%h got=%0d exp=1", addr, lat0); end
    checks++;
    if (lat3 !== 4) begin failures++; $display("[TB] FAIL ws3_latency addr=%h got=%0d exp=4", addr, lat3); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready0, err0, rdata0, tdr0, tcr0, tsr0} !== 27'd0) begin
      failures++; $display("[TB] FAIL reset_ws0 got=%h exp=0", {ready0, err0, rdata0, tdr0, tcr0, tsr0});
    end
    checks++;
    if ({ready3, err3, rdata3, tdr3, tcr3, tsr3} !== 27'd0) begin
      failures++; $display("[TB] FAIL reset_ws3 got=%h exp=0", {ready3, err3, rdata3, tdr3, tcr3, tsr3});
    end
  endtask

  task automatic test_idle_ignore();
    int seen;
    seen = 0;
    @(negedge cpu_clk);
    cpu_sel = 1'b1; cpu_enable = 1'b1; cpu_write = 1'b1; cpu_address = 8'h00; cpu_wdata = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge cpu_clk); #1;
      if (ready0 || ready3) seen++;
    end
    @(negedge cpu_clk);
    cpu_sel = 1'b0; cpu_enable = 1'b0;
    checks++;
    if (seen !== 0) begin failures++; $display("[TB] FAIL idle_ignore_ready got=%0d exp=0", seen); end
    checks++;
    if ({tdr0, tdr3} !== 16'h0000) begin failures++; $display("[TB] FAIL idle_ignore_tdr got=%h exp=0000", {tdr0, tdr3}); end
  endtask

  task automatic test_tdr();
    xfer(1'b1, 8'h00, 8'hA5);
    checks++;
    if ({tdr0, tdr3} !== 16'hA5A5) begin failures++; $display("[TB] FAIL tdr_out got=%h exp=a5a5", {tdr0, tdr3}); end
    checks++;
    if ({e0, e3} !== 2'b00) begin failures++; $display("[TB] FAIL tdr_wr_slverr got=%b exp=00", {e0, e3}); end
    xfer(1'b0, 8'h00, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'hA5A5) begin failures++; $display("[TB] FAIL tdr_read got=%h exp=a5a5", {rd0, rd3}); end
    checks++;
    if ({e0, e3} !== 2'b00) begin failures++; $display("[TB] FAIL tdr_rd_slverr got=%b exp=00", {e0, e3}); end
  endtask

  task automatic test_tcr_mask();
    xfer(1'b1, 8'h01, 8'hFF);
    checks++;
    if ({tcr0, tcr3} !== 16'hB3B3) begin failures++; $display("[TB] FAIL tcr_out got=%h exp=b3b3", {tcr0, tcr3}); end
    xfer(1'b0, 8'h01, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'hB3B3) begin failures++; $display("[TB] FAIL tcr_read got=%h exp=b3b3", {rd0, rd3}); end
  endtask

  task automatic test_slverr();
    xfer(1'b1, 8'h05, 8'h12);
    checks++;
    if ({e0, e3} !== 2'b11) begin failures++; $display("[TB] FAIL unmapped_wr_slverr got=%b exp=11", {e0, e3}); end
    checks++;
    if ({tdr0, tcr0, tsr0, tdr3, tcr3, tsr3} !== {8'hA5, 8'hB3, 2'b00, 8'hA5, 8'hB3, 2'b00}) begin
      failures++; $display("[TB] FAIL unmapped_no_change got=%h exp=%h",
                           {tdr0, tcr0, tsr0, tdr3, tcr3, tsr3}, {8'hA5, 8'hB3, 2'b00, 8'hA5, 8'hB3, 2'b00});
    end
    xfer(1'b0, 8'hFF, 8'h00);
    checks++;
    if ({e0, e3} !== 2'b11) begin failures++; $display("[TB] FAIL unmapped_rd_slverr got=%b exp=11", {e0, e3}); end
    checks++;
    if ({rd0, rd3} !== 16'h0000) begin failures++; $display("[TB] FAIL unmapped_rdata got=%h exp=0000", {rd0, rd3}); end
  endtask

  task automatic test_status();
    @(negedge cpu_clk); ovf_set = 1'b1;
    @(negedge cpu_clk); ovf_set = 1'b0;
    checks++;
    if ({tsr0, tsr3} !== 4'b0101) begin failures++; $display("[TB] FAIL tsr_ovf_set got=%b exp=0101", {tsr0, tsr3}); end
    xfer(1'b0, 8'h02, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'h0101) begin failures++; $display("[TB] FAIL tsr_read_ovf got=%h exp=0101", {rd0, rd3}); end
    udf_set = 1'b1;
    xfer(1'b1, 8'h02, 8'h01);
    udf_set = 1'b0;
    xfer(1'b0, 8'h02, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'h0202) begin failures++; $display("[TB] FAIL tsr_w1c_with_udf got=%h exp=0202", {rd0, rd3}); end
    ovf_set = 1'b1;
    xfer(1'b1, 8'h02, 8'h03);
    ovf_set = 1'b0;
    checks++;
    if ({tsr0, tsr3} !== 4'b0101) begin failures++; $display("[TB] FAIL tsr_set_wins got=%b exp=0101", {tsr0, tsr3}); end
    xfer(1'b1, 8'h02, 8'h00);
    xfer(1'b0, 8'h02, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'h0101) begin failures++; $display("[TB] FAIL tsr_write0_noeffect got=%h exp=0101", {rd0, rd3}); end
  endtask

  task automatic test_tcnt();
    cnt_in = 8'h3C;
    xfer(1'b0, 8'h03, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'h3C3C) begin failures++; $display("[TB] FAIL tcnt_read got=%h exp=3c3c", {rd0, rd3}); end
    xfer(1'b1, 8'h03, 8'h00);
    checks++;
    if ({e0, e3} !== 2'b00) begin failures++; $display("[TB] FAIL tcnt_wr_slverr got=%b exp=00", {e0, e3}); end
    xfer(1'b0, 8'h03, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'h3C3C) begin failures++; $display("[TB] FAIL tcnt_reread got=%h exp=3c3c", {rd0, rd3}); end
    checks++;
    if ({tdr0, tdr3} !== 16'hA5A5) begin failures++; $display("[TB] FAIL tcnt_wr_no_side got=%h exp=a5a5", {tdr0, tdr3}); end
  endtask

  task automatic test_reset_midtransfer();
    int seen;
    seen = 0;
    @(negedge cpu_clk);
    cpu_sel = 1'b1; cpu_enable = 1'b0; cpu_write = 1'b1; cpu_address = 8'h00; cpu_wdata = 8'h77;
    @(negedge cpu_clk);
    cpu_enable = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_reset_n = 1'b0;
    @(posedge cpu_clk); #1;
    if (ready0 || ready3) seen++;
    @(negedge cpu_clk);
    cpu_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge cpu_clk); #1;
      if (ready0 || ready3) seen++;
    end
    @(negedge cpu_clk);
    cpu_sel = 1'b0; cpu_enable = 1'b0;
    checks++;
    if (seen !== 0) begin failures++; $display("[TB] FAIL midreset_ready got=%0d exp=0", seen); end
    checks++;
    if ({tdr0, tdr3} !== 16'h0000) begin failures++; $display("[TB] FAIL midreset_tdr got=%h exp=0000", {tdr0, tdr3}); end
    xfer(1'b1, 8'h00, 8'h77);
    xfer(1'b0, 8'h00, 8'h00);
    checks++;
    if ({rd0, rd3} !== 16'h7777) begin failures++; $display("[TB] FAIL postreset_read got=%h exp=7777", {rd0, rd3}); end
    checks++;
    if ({tdr0, tdr3} !== 16'h7777) begin failures++; $display("[TB] FAIL postreset_tdr got=%h exp=7777", {tdr0, tdr3}); end
  endtask

  // Hard stop in case a task hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    repeat (2) @(posedge cpu_clk);
    test_reset();
    @(negedge cpu_clk);
    cpu_reset_n = 1'b1;
    test_idle_ignore();
    test_tdr();
    test_tcr_mask();
    test_slverr();
    test_status();
    test_tcnt();
    test_reset_midtransfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_apb_slave.md
Name: timer_apb_slave

Overview:
- Bus-side responder for the cpu_sel/cpu_enable/cpu_write/cpu_ready protocol driven by the CPU-side initiator.
- Decodes a 4-register timer bank, applies programmable wait states and signals slave error on unmapped addresses.
- Exports control/reload values to the timer counter core and accepts status-set pulses and the live count from it.

Parameters:
- WAIT_STATES, 0, extra access-phase cycles before cpu_ready; legal 0..7.

Ports:
- cpu_clk  input  1  system clock, all logic on rising edge
- cpu_reset_n  input  1  asynchronous active-low reset
- cpu_sel  input  1  slave select
- cpu_enable  input  1  access-phase qualifier
- cpu_write  input  1  1 = write, 0 = read
- cpu_address  input  8  register address
- cpu_wdata  input  8  write data
- cpu_ready  output  1  transfer complete, registered, one-cycle pulse
- cpu_slverr  output  1  unmapped address, valid only with cpu_ready
- cpu_rdata  output  8  read data, valid only with cpu_ready
- tdr_out  output  8  reload value (TDR)
- tcr_out  output  8  control register (TCR)
- ovf_set  input  1  counter overflow pulse
- udf_set  input  1  counter underflow pulse
- cnt_in  input  8  live counter value
- tsr_out  output  2  status flags {udf, ovf}

Behaviour:
- Reset values: all outputs and registers are 8'h00 or 0; FSM = IDLE.
- Register map:
  - 0x00 TDR: read/write, 8 bits.
  - 0x01 TCR: read/write; bits 6, 3 and 2 are reserved, write-ignored, read 0.
  - 0x02 TSR: bits [1:0] are write-1-to-clear; bits [7:2] read 0.
  - 0x03 TCNT: read returns cnt_in; writes are ignored but complete without error.
  - 0x04..0xFF: cpu_slverr = 1 with cpu_ready; no register change; cpu_rdata = 8'h00.
- FSM:
  - IDLE: go to SETUP when sel=1 and enable=0 are sampled. sel=1 with enable=1 seen directly in IDLE is ignored; stay IDLE with no ready.
  - SETUP: on sel=1 and enable=1, go to ACCESS and load the wait counter with WAIT_STATES. On sel=0, go to IDLE.
  - ACCESS: if the counter is 0, commit the write or capture read data, assert cpu_ready and cpu_slverr/cpu_rdata in the same registered update, and go to RESP. Otherwise decrement the counter. If sel or enable drops, abort to IDLE with no commit.
  - RESP: cpu_ready is high for exactly this cycle. Unconditionally go to IDLE, then drop cpu_ready, cpu_slverr and cpu_rdata to 0. sel/enable still high in this cycle (initiator release delay) must not start a new transfer.
- Latency: the initiator samples cpu_ready WAIT_STATES+1 edges after the first edge that sees sel&enable.
- Commit timing: writes take effect in the same edge that raises cpu_ready. Read data is captured at that edge, so it is stable for the whole RESP cycle.
- TSR flags:
  - An ovf_set/udf_set pulse sets its flag.
  - A bus W1C on the same edge as a set pulse leaves the flag set (set wins).
  - Writing 0 to a bit has no effect.
- tdr_out, tcr_out and tsr_out reflect register contents directly with no extra latency.
- Reset asserted mid-transfer: immediate return to the reset state. Any uncommitted write is lost, and cpu_ready stays low until a fresh SETUP.

Decomposition:
- Shared package timer_pkg holds:
  - address constants ADDR_TDR/TCR/TSR/TCNT;
  - TCR_WMASK = 8'hB3;
  - RESET_VALUE = 8'h00;
  - FSM state enum {IDLE, SETUP, ACCESS, RESP}.
- No sub-module: the register bank and FSM form a single module. The wait counter is 3-bit inline logic.

Test Plan:
- WAIT_STATES=0: write 0x00 <- 8'hA5, then read 0x00 -> rdata 8'hA5, slverr 0, ready seen 1 edge after enable; tdr_out = 8'hA5.
- WAIT_STATES=3: write 0x01 <- 8'hFF -> ready seen 4 edges after enable; read 0x01 -> 8'hB3; tcr_out = 8'hB3.
- Write 0x05 <- 8'h12 and read 0xFF -> slverr 1 with ready, rdata 8'h00, no register changed.
- Pulse ovf_set, then read 0x02 -> 8'h01. Write 0x02 <- 8'h01 on the same edge as a udf_set pulse -> then read 0x02 -> 8'h02.
- Drive cnt_in = 8'h3C, read 0x03 -> 8'h3C. Write 0x03 <- 8'h00 -> ready, slverr 0, next read still 8'h3C.
- Assert cpu_reset_n low during ACCESS of write 0x00 <- 8'h77 -> no ready, tdr_out stays 8'h00, the next full transfer completes normally.
